// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg
//   Shared definitions for the two-requester ALU sharing controller:
//   ALU op codes, controller FSM states and the illegal-op check.
package alu_share_ctrl_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // 011 and 111 are the only unassigned codes.
    function automatic logic op_illegal(input logic [2:0] op);
        return (op[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/Alu.sv
// Alu
//   32-bit combinational ALU shared by the controller.
//   a, b      operands
//   op        operation code (see alu_share_ctrl_pkg)
//   unsig     selects unsigned compare and suppresses signed overflow
//   aluout    result (0 for illegal op codes)
//   compout   a < b, signed or unsigned per unsig
//   overflow  signed overflow of add/sub (0 when unsig or other ops)
module Alu
    import alu_share_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic        unsig,
    output logic [31:0] aluout,
    output logic        compout,
    output logic        overflow
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        aluout   = '0;
        overflow = 1'b0;
        case (op)
            OP_AND: aluout = a & b;
            OP_OR:  aluout = a | b;
            OP_ADD: begin
                aluout   = sum;
                overflow = !unsig && (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_NOR: aluout = ~(a | b);
            OP_XOR: aluout = a ^ b;
            OP_SUB: begin
                aluout   = diff;
                overflow = !unsig && (a[31] != b[31]) && (diff[31] != a[31]);
            end
            default: aluout = '0;
        endcase
    end

    assign compout = unsig ? (a < b) : ($signed(a) < $signed(b));

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2
//   Combinational 2-way round-robin arbiter.
//   req_i   [1:0]  request vector
//   last_i         index of the requester granted most recently
//   grant_o [1:0]  one-hot grant (zero when no request)
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        if (req_i == 2'b11) begin
            // Tie goes to whoever did not win last time.
            grant_o = last_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = req_i;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one Alu between two requesters. Round-robin grant in IDLE,
//   operands latched on handshake, fixed EXEC_CYCLES execute window, then a
//   one-cycle rsp_valid pulse tagged to the winner. Illegal op codes skip
//   the execute window and report rsp_err with zero result.
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready per-requester handshake
//   req{0,1}_{a,b}      operands; req_op = {op1, op0}; req_unsig per requester
//   rsp_valid           one-hot result pulse
//   rsp_data/comp/ovf   registered Alu outputs; rsp_err flags illegal op
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [5:0]  req_op,
    input  logic [1:0]  req_unsig,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_comp,
    output logic        rsp_ovf,
    output logic        rsp_err
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              unsig_q, unsig_d;
    logic [31:0]       data_q, data_d;
    logic              comp_q, comp_d, ovf_q, ovf_d, err_q, err_d;

    logic [1:0]  grant;
    logic        gnt_id;
    logic        xfer;
    logic [2:0]  sel_op;
    logic [31:0] alu_out;
    logic        alu_comp, alu_ovf;

    rr_arb2 u_arb (
        .req_i   (req_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    // Alu sees only latched operands, so its inputs are stable outside EXEC.
    Alu u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .unsig    (unsig_q),
        .aluout   (alu_out),
        .compout  (alu_comp),
        .overflow (alu_ovf)
    );

    assign gnt_id = grant[1];
    assign sel_op = gnt_id ? req_op[5:3] : req_op[2:0];
    assign xfer   = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            unsig_q <= 1'b0;
            data_q  <= '0;
            comp_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            unsig_q <= unsig_d;
            data_q  <= data_d;
            comp_q  <= comp_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        unsig_d = unsig_q;
        data_d  = data_q;
        comp_d  = comp_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    a_d     = gnt_id ? req1_a : req0_a;
                    b_d     = gnt_id ? req1_b : req0_b;
                    op_d    = sel_op;
                    unsig_d = req_unsig[gnt_id];
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    cnt_d   = '0;
                    if (op_illegal(sel_op)) begin
                        data_d  = '0;
                        comp_d  = 1'b0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(EXEC_CYCLES - 1)) begin
                    data_d  = alu_out;
                    comp_d  = alu_comp;
                    ovf_d   = alu_ovf;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (!rst) begin
            if (state_q == ST_IDLE) begin
                req_ready = grant;
            end
            if (state_q == ST_DONE) begin
                rsp_valid = id_q ? 2'b10 : 2'b01;
            end
        end
    end

    assign rsp_data = data_q;
    assign rsp_comp = comp_q;
    assign rsp_ovf  = ovf_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0]  req_op;
    logic [1:0]  req_unsig;

    logic [1:0]  rdy1, rv1, rdy3, rv3;
    logic [31:0] data1, data3;
    logic        comp1, ovf1, err1, comp3, ovf3, err3;

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_ctrl #(.EXEC_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req_op(req_op), .req_unsig(req_unsig), .rsp_valid(rv1),
        .rsp_data(data1), .rsp_comp(comp1), .rsp_ovf(ovf1), .rsp_err(err1)
    );

    alu_share_ctrl #(.EXEC_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req_op(req_op), .req_unsig(req_unsig), .rsp_valid(rv3),
        .rsp_data(data3), .rsp_comp(comp3), .rsp_ovf(ovf3), .rsp_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_op = '0; req_unsig = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        cyc(); cyc();
        #1;
        check("rst_ready", 32'(rdy1), 32'h0);
        check("rst_rvalid", 32'(rv1), 32'h0);
        check("rst_data", data1, 32'h0);
        check("rst_err", 32'(err1), 32'h0);

        // 1: single add from req0
        rst = 1'b0; req_valid = 2'b01; req0_a = 32'd5; req0_b = 32'd3; req_op = 6'b000_010;
        #1 check("t1_ready_N", 32'(rdy1), 32'h1);
        cyc(); req_valid = 2'b00;
        #1 check("t1_rvalid_N1", 32'(rv1), 32'h0);
        check("t1_ready_N1", 32'(rdy1), 32'h0);
        cyc();
        #1 check("t1_rvalid_N2", 32'(rv1), 32'h1);
        check("t1_data", data1, 32'd8);
        check("t1_err", 32'(err1), 32'h0);
        check("t1_comp", 32'(comp1), 32'h0);
        cyc();
        #1 check("t1_rvalid_off", 32'(rv1), 32'h0);
        check("t1_data_hold", data1, 32'd8);

        // 2: tie after reset, req0 first
        rst = 1'b1; cyc(); rst = 1'b0;
        req_valid = 2'b11;
        req0_a = 32'hF0F0F0F0; req0_b = 32'h0F0F0F0F;
        req1_a = 32'd10; req1_b = 32'd3; req_op = 6'b110_101;
        #1 check("t2_ready_first", 32'(rdy1), 32'h1);
        cyc(); req_valid = 2'b10;
        #1 check("t2_ready_exec", 32'(rdy1), 32'h0);
        cyc();
        #1 check("t2_rvalid0", 32'(rv1), 32'h1);
        check("t2_data0", data1, 32'hFFFFFFFF);
        check("t2_comp0", 32'(comp1), 32'h1);
        check("t2_ready_done", 32'(rdy1), 32'h0);
        cyc();
        #1 check("t2_ready_second", 32'(rdy1), 32'h2);
        cyc(); req_valid = 2'b00;
        cyc();
        #1 check("t2_rvalid1", 32'(rv1), 32'h2);
        check("t2_data1", data1, 32'd7);
        check("t2_comp1", 32'(comp1), 32'h0);
        cyc();

        // 3: both held valid for four ops -> 0,1,0,1
        req_valid = 2'b11;
        for (int k = 0; k < 12; k++) begin
            if (k == 10) req_valid = 2'b00;
            #1;
            check($sformatf("t3_ready_%0d", k), 32'(rdy1),
                  (k % 3 == 0) ? (((k / 3) % 2 == 1) ? 32'h2 : 32'h1) : 32'h0);
            check($sformatf("t3_rvalid_%0d", k), 32'(rv1),
                  (k % 3 == 2) ? (((k / 3) % 2 == 1) ? 32'h2 : 32'h1) : 32'h0);
            if (k % 3 == 2)
                check($sformatf("t3_data_%0d", k), data1,
                      ((k / 3) % 2 == 1) ? 32'd7 : 32'hFFFFFFFF);
            cyc();
        end

        // 4: illegal op from req1
        req_valid = 2'b10; req_op = 6'b011_010;
        #1 check("t4_ready", 32'(rdy1), 32'h2);
        cyc(); req_valid = 2'b00;
        #1 check("t4_rvalid_N1", 32'(rv1), 32'h2);
        check("t4_err", 32'(err1), 32'h1);
        check("t4_data", data1, 32'h0);
        check("t4_comp", 32'(comp1), 32'h0);
        check("t4_ovf", 32'(ovf1), 32'h0);
        cyc();

        // unsigned compare from req1, err clears on legal result
        req_valid = 2'b10; req_op = 6'b110_010; req_unsig = 2'b10;
        req1_a = 32'd1; req1_b = 32'hFFFFFFFF;
        #1 check("tu_ready", 32'(rdy1), 32'h2);
        cyc(); req_valid = 2'b00;
        #1 check("tu_err_hold", 32'(err1), 32'h1);
        cyc();
        #1 check("tu_rvalid", 32'(rv1), 32'h2);
        check("tu_data", data1, 32'd2);
        check("tu_comp", 32'(comp1), 32'h1);
        check("tu_err_clr", 32'(err1), 32'h0);
        cyc();

        // signed add overflow from req0
        req_valid = 2'b01; req_unsig = 2'b00; req0_a = 32'h7FFFFFFF; req0_b = 32'd1;
        #1 check("to_ready", 32'(rdy1), 32'h1);
        cyc(); req_valid = 2'b00;
        cyc();
        #1 check("to_rvalid", 32'(rv1), 32'h1);
        check("to_data", data1, 32'h80000000);
        check("to_ovf", 32'(ovf1), 32'h1);
        check("to_comp", 32'(comp1), 32'h0);
        cyc();

        // 5: reset during EXEC (last grant was req0)
        req_valid = 2'b01;
        #1 check("t5_ready", 32'(rdy1), 32'h1);
        cyc(); rst = 1'b1; req_valid = 2'b00;
        #1 check("t5_ready_rst", 32'(rdy1), 32'h0);
        cyc(); rst = 1'b0; req_valid = 2'b11;
        #1 check("t5_rvalid", 32'(rv1), 32'h0);
        check("t5_data", data1, 32'h0);
        check("t5_ovf", 32'(ovf1), 32'h0);
        check("t5_err", 32'(err1), 32'h0);
        check("t5_tie_req0", 32'(rdy1), 32'h1);
        cyc(); req_valid = 2'b00;
        cyc(); cyc(); cyc();

        // 6: EXEC_CYCLES=3, nor of zeros, valid held throughout
        rst = 1'b1; cyc(); rst = 1'b0;
        req_valid = 2'b01; req0_a = 32'h0; req0_b = 32'h0; req_op = 6'b000_100;
        #1 check("t6_ready_N", 32'(rdy3), 32'h1);
        cyc();
        for (int j = 1; j <= 3; j++) begin
            #1;
            check($sformatf("t6_ready_N%0d", j), 32'(rdy3), 32'h0);
            check($sformatf("t6_rvalid_N%0d", j), 32'(rv3), 32'h0);
            cyc();
        end
        #1 check("t6_rvalid_N4", 32'(rv3), 32'h1);
        check("t6_data", data3, 32'hFFFFFFFF);
        check("t6_ready_N4", 32'(rdy3), 32'h0);
        req_valid = 2'b00;
        cyc();
        #1 check("t6_rvalid_off", 32'(rv3), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
